// File: rtl/variable_pkg.sv
// Shared constants, FSM state type and hit-point helper for the throw-game controller.
package variable_pkg;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  localparam logic [6:0] HP_MAX = 7'd100;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHARGE    = 2'd1,
    FLIGHT    = 2'd2,
    GAME_OVER = 2'd3
  } turn_state_t;

  // The simulator's 7-bit subtraction wraps, so anything above HP_MAX is a dead player too.
  function automatic logic is_dead(input logic [6:0] hp);
    return (hp == 7'd0) || (hp > HP_MAX);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for an already-synchronised button level.
// The previous-level flop resets high so a button held through reset yields no edge.
module btn_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b1;
    else         prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/turn_ctrl.sv
// Throw-game flow controller: charge speed from the button, launch, alternate turns, latch game over.
// Defining TURN_CTRL_TIMEOUT_EN adds a flight watchdog that hands the turn over if end_throw never arrives.
module turn_ctrl
  import variable_pkg::*;
#(
  parameter int CHARGE_TICK    = 3_000_000,
  parameter int MIN_SPEED      = 1,
  parameter int MAX_SPEED      = 31,
  parameter int FLIGHT_TIMEOUT = 600_000_000
) (
  input  logic       clk60MHz,
  input  logic       rst_n,
  input  logic       btn_throw,
  input  logic       end_throw,
  input  logic [6:0] hp_player1,
  input  logic [6:0] hp_player2,
  output logic       throw_flag,
  output logic       turn,
  output logic [4:0] speed,
  output logic       charging,
  output logic       game_over,
  output logic       winner
);

  localparam int TICK_W = (CHARGE_TICK > 1) ? $clog2(CHARGE_TICK) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CHARGE_TICK - 1);
  localparam logic [4:0] MIN_SPD = 5'(MIN_SPEED);
  localparam logic [5:0] MAX_SPD = 6'(MAX_SPEED);

  turn_state_t       state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [4:0]        speed_q, speed_d;
  logic              turn_q, turn_d;
  logic              throw_q, throw_d;
  logic              charging_q, charging_d;
  logic              over_q, over_d;
  logic              winner_q, winner_d;
  logic              btn_rise;
  logic [5:0]        speed_inc;
  logic              dead1, dead2;

  btn_edge u_btn_edge (
    .clk_i  (clk60MHz),
    .rst_ni (rst_n),
    .btn_i  (btn_throw),
    .rise_o (btn_rise)
  );

  assign speed_inc = {1'b0, speed_q} + 6'd1;
  assign dead1     = is_dead(hp_player1);
  assign dead2     = is_dead(hp_player2);

`ifdef TURN_CTRL_TIMEOUT_EN
  localparam logic [29:0] FLIGHT_LAST = 30'(FLIGHT_TIMEOUT - 1);
  logic [29:0] flight_q, flight_d;
`else
  logic unused_timeout;
  assign unused_timeout = (FLIGHT_TIMEOUT == 0);
`endif

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    speed_d    = speed_q;
    turn_d     = turn_q;
    throw_d    = 1'b0;
    charging_d = 1'b0;
    over_d     = over_q;
    winner_d   = winner_q;
`ifdef TURN_CTRL_TIMEOUT_EN
    flight_d   = 30'd0;
`endif
    case (state_q)
      IDLE: begin
        speed_d = MIN_SPD;
        if (btn_rise) begin
          state_d    = CHARGE;
          tick_d     = '0;
          charging_d = 1'b1;
        end
      end
      CHARGE: begin
        if (!btn_throw) begin
          state_d = FLIGHT;
          throw_d = 1'b1;
        end else begin
          charging_d = 1'b1;
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (speed_inc <= MAX_SPD) speed_d = speed_inc[4:0];
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      FLIGHT: begin
        if (end_throw) begin
          if (dead1 || dead2) begin
            state_d  = GAME_OVER;
            over_d   = 1'b1;
            winner_d = (dead1 && dead2) ? turn_q : (dead2 ? PLAYER_1 : PLAYER_2);
          end else begin
            state_d = IDLE;
            turn_d  = ~turn_q;
            speed_d = MIN_SPD;
          end
        end
`ifdef TURN_CTRL_TIMEOUT_EN
        else if (flight_q == FLIGHT_LAST) begin
          state_d = IDLE;
          turn_d  = ~turn_q;
          speed_d = MIN_SPD;
        end else begin
          flight_d = flight_q + 30'd1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      speed_q    <= MIN_SPD;
      turn_q     <= PLAYER_1;
      throw_q    <= 1'b0;
      charging_q <= 1'b0;
      over_q     <= 1'b0;
      winner_q   <= PLAYER_1;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      speed_q    <= speed_d;
      turn_q     <= turn_d;
      throw_q    <= throw_d;
      charging_q <= charging_d;
      over_q     <= over_d;
      winner_q   <= winner_d;
    end
  end

`ifdef TURN_CTRL_TIMEOUT_EN
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) flight_q <= 30'd0;
    else        flight_q <= flight_d;
  end
`endif

  assign throw_flag = throw_q;
  assign turn       = turn_q;
  assign speed      = speed_q;
  assign charging   = charging_q;
  assign game_over  = over_q;
  assign winner     = winner_q;

endmodule
